// File: rtl/ddr3_read_arbiter.sv
// Purpose : round-robin share of one DDR3 read port between two address requesters,
//           with an in-order owner tag FIFO that steers returned read data back.
// Latency : address path combinational in a grant state (1-cycle idle bubble per grant);
//           read data reaches the owner's rsp port 1 cycle after the DDR3 beat.
// Backpressure: requester ready follows mem_addr_ready_i; issue stalls (grant held) while
//           MAX_OUTSTANDING reads are in flight. Read data has no backpressure.
// Ports   : clk_i, reset_n_i (async active-low); req{0,1}_addr_{data,valid}_i / _ready_o;
//           mem_addr_{data,valid}_o / mem_addr_ready_i; mem_rdata{,_valid}_i;
//           rsp{0,1}_{data,valid}_o; outstanding_o; rsp_err_o (sticky).
module ddr3_read_arbiter #(
  parameter int ADDR_W          = 29,
  parameter int DATA_W          = 256,
  parameter int BURST_LEN       = 3,
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] req0_addr_data_i,
  input  logic              req0_addr_valid_i,
  output logic              req0_addr_ready_o,
  input  logic [ADDR_W-1:0] req1_addr_data_i,
  input  logic              req1_addr_valid_i,
  output logic              req1_addr_ready_o,
  output logic [ADDR_W-1:0] mem_addr_data_o,
  output logic              mem_addr_valid_o,
  input  logic              mem_addr_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rdata_valid_i,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              rsp1_valid_o,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              rsp_err_o
);

  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;

  state_e                     state_q;
  logic                       last_grant_q;
  logic [BEAT_W-1:0]          beat_cnt_q;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic                       rsp0_valid_q;
  logic                       rsp1_valid_q;
  logic [DATA_W-1:0]          rsp0_data_q;
  logic [DATA_W-1:0]          rsp1_data_q;
  logic                       rsp_err_q;

  logic grant0;
  logic grant1;
  logic owner_valid;
  logic tag_full;
  logic accept;
  logic pop;
  logic head_tag;

  // Full is taken from the registered count, so a pop in the same cycle
  // only unblocks issue on the following cycle.
  assign tag_full    = (cnt_q == CNT_FULL);
  assign grant0      = (state_q == ST_GRANT0);
  assign grant1      = (state_q == ST_GRANT1);
  assign owner_valid = grant1 ? req1_addr_valid_i : req0_addr_valid_i;

  assign mem_addr_data_o   = grant1 ? req1_addr_data_i : req0_addr_data_i;
  assign mem_addr_valid_o  = (grant0 | grant1) & owner_valid & ~tag_full;
  assign req0_addr_ready_o = grant0 & mem_addr_ready_i & ~tag_full;
  assign req1_addr_ready_o = grant1 & mem_addr_ready_i & ~tag_full;

  assign accept   = mem_addr_valid_o & mem_addr_ready_i;
  assign head_tag = tag_q[rd_ptr_q];
  // A beat with nothing logged is not popped; it only raises the error flag.
  assign pop      = mem_rdata_valid_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !accept) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Grant FSM. The grant lasts for up to BURST_LEN accepts so consecutive
  // addresses of one requester stay contiguous at the DDR3 port; it is
  // released as soon as the owner drops valid.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_addr_valid_i && (!req1_addr_valid_i || last_grant_q)) begin
            state_q <= ST_GRANT0;
          end else if (req1_addr_valid_i) begin
            state_q <= ST_GRANT1;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (!owner_valid || (accept && (beat_cnt_q == BEAT_LAST))) begin
            state_q      <= ST_IDLE;
            last_grant_q <= grant1;
            beat_cnt_q   <= '0;
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  // Owner tag FIFO: one bit per read in flight, 1 = requester 1.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        tag_q[wr_ptr_q] <= grant1;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // Registered response steering; data registers hold their last value.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp0_valid_q <= pop & ~head_tag;
      rsp1_valid_q <= pop & head_tag;
      if (pop && !head_tag) begin
        rsp0_data_q <= mem_rdata_i;
      end
      if (pop && head_tag) begin
        rsp1_data_q <= mem_rdata_i;
      end
      if (mem_rdata_valid_i && !pop) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign rsp0_valid_o  = rsp0_valid_q;
  assign rsp1_valid_o  = rsp1_valid_q;
  assign rsp0_data_o   = rsp0_data_q;
  assign rsp1_data_o   = rsp1_data_q;
  assign outstanding_o = cnt_q;
  assign rsp_err_o     = rsp_err_q;

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
// Purpose : self-checking bench for ddr3_read_arbiter (directed scenarios + random traffic).
// Latency : checks rsp one cycle after each beat; samples 1-2 time units after posedge.
// Backpressure: randomizes mem_addr_ready and requester valid; requesters hold data until ready.
module tb_ddr3_read_arbiter;
  localparam int AW = 29;
  localparam int DW = 256;
  localparam int BL = 3;
  localparam int MO = 16;
  localparam int CW = $clog2(MO) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] req0_addr, req1_addr, mem_addr;
  logic          req0_vld, req1_vld, req0_rdy, req1_rdy;
  logic          mem_vld, mem_rdy;
  logic [DW-1:0] mem_rdata, rsp0_dat, rsp1_dat;
  logic          mem_rdata_vld, rsp0_vld, rsp1_vld, rsp_err;
  logic [CW-1:0] outstanding;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr3_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .req0_addr_data_i (req0_addr),
    .req0_addr_valid_i(req0_vld),
    .req0_addr_ready_o(req0_rdy),
    .req1_addr_data_i (req1_addr),
    .req1_addr_valid_i(req1_vld),
    .req1_addr_ready_o(req1_rdy),
    .mem_addr_data_o  (mem_addr),
    .mem_addr_valid_o (mem_vld),
    .mem_addr_ready_i (mem_rdy),
    .mem_rdata_i      (mem_rdata),
    .mem_rdata_valid_i(mem_rdata_vld),
    .rsp0_data_o      (rsp0_dat),
    .rsp0_valid_o     (rsp0_vld),
    .rsp1_data_o      (rsp1_dat),
    .rsp1_valid_o     (rsp1_vld),
    .outstanding_o    (outstanding),
    .rsp_err_o        (rsp_err)
  );

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Leaves time at posedge+1 with reset released and all inputs idle.
  task automatic apply_reset();
    reset_n = 1'b0;
    req0_vld = 0; req1_vld = 0; req0_addr = '0; req1_addr = '0;
    mem_rdy = 0; mem_rdata_vld = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (outstanding !== 0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (rsp0_vld !== 0 || rsp1_vld !== 0) begin failures++; $display("FAIL reset_rsp_valid got=%b%b exp=00", rsp0_vld, rsp1_vld); end
    checks++; if (rsp_err !== 0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (rsp0_dat !== '0 || rsp1_dat !== '0) begin failures++; $display("FAIL reset_rsp_data got nonzero exp=0"); end
    checks++; if (mem_vld !== 0 || req0_rdy !== 0 || req1_rdy !== 0) begin failures++; $display("FAIL reset_handshake got=%b%b%b exp=000", mem_vld, req0_rdy, req1_rdy); end
  endtask

  task automatic test_single_port();
    int idx = 0;
    apply_reset();
    mem_rdy = 1;
    for (int c = 0; c < 6; c++) begin
      bit exp_v;
      req0_vld = (idx < 3); req0_addr = AW'(32'h100 + idx);
      #1;
      exp_v = (c >= 1 && c <= 3);
      checks++; if (mem_vld !== exp_v) begin failures++; $display("FAIL single_mem_valid cyc=%0d got=%b exp=%b", c, mem_vld, exp_v); end
      if (exp_v) begin
        checks++; if (mem_addr !== AW'(32'h100 + c - 1)) begin failures++; $display("FAIL single_mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, 32'h100 + c - 1); end
      end
      if (req0_vld && req0_rdy) idx++;
      @(posedge clk); #1;
    end
    req0_vld = 0;
    checks++; if (outstanding !== 3) begin failures++; $display("FAIL single_outstanding got=%0d exp=3", outstanding); end
  endtask

  task automatic test_round_robin();
    int exp_own [9] = '{-1, 0, 0, 0, -1, 1, 1, 1, -1};
    int n0 = 0, n1 = 0;
    apply_reset();
    mem_rdy = 1;
    for (int c = 0; c < 9; c++) begin
      int own;
      req0_vld = 1; req0_addr = AW'(32'h200 + n0);
      req1_vld = 1; req1_addr = AW'(32'h300 + n1);
      #1;
      own = (req0_vld && req0_rdy) ? 0 : (req1_vld && req1_rdy) ? 1 : -1;
      checks++; if (own != exp_own[c]) begin failures++; $display("FAIL rr_owner cyc=%0d got=%0d exp=%0d", c, own, exp_own[c]); end
      if (own == 0) begin
        checks++; if (mem_addr !== req0_addr) begin failures++; $display("FAIL rr_addr0 got=%h exp=%h", mem_addr, req0_addr); end
        n0++;
      end else if (own == 1) begin
        checks++; if (mem_addr !== req1_addr) begin failures++; $display("FAIL rr_addr1 got=%h exp=%h", mem_addr, req1_addr); end
        n1++;
      end
      @(posedge clk); #1;
    end
    req0_vld = 0; req1_vld = 0;
    @(posedge clk); #1;
    checks++; if (outstanding !== 6) begin failures++; $display("FAIL rr_outstanding got=%0d exp=6", outstanding); end
  endtask

  // Relies on the 0,0,0,1,1,1 issue order left by test_round_robin.
  task automatic test_interleaved_returns();
    logic [DW-1:0] d [6];
    for (int k = 0; k < 6; k++) d[k] = rand_data();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        int o = (k - 1 < 3) ? 0 : 1;
        checks++; if (rsp0_vld !== (o == 0) || rsp1_vld !== (o == 1)) begin failures++; $display("FAIL il_valid beat=%0d got=%b%b exp_owner=%0d", k - 1, rsp0_vld, rsp1_vld, o); end
        checks++; if ((o == 0 ? rsp0_dat : rsp1_dat) !== d[k-1]) begin failures++; $display("FAIL il_data beat=%0d got=%h exp=%h", k - 1, (o == 0 ? rsp0_dat : rsp1_dat), d[k-1]); end
      end
      mem_rdata_vld = (k < 6);
      mem_rdata     = (k < 6) ? d[k] : '0;
      @(posedge clk); #1;
    end
    mem_rdata_vld = 0;
    checks++; if (outstanding !== 0 || rsp0_vld !== 0 || rsp1_vld !== 0) begin failures++; $display("FAIL il_drained got out=%0d v=%b%b exp out=0 v=00", outstanding, rsp0_vld, rsp1_vld); end
  endtask

  task automatic test_full();
    int n = 0;
    apply_reset();
    mem_rdy = 1; req0_vld = 1;
    for (int c = 0; c < 60 && outstanding !== CW'(MO); c++) begin
      req0_addr = AW'(32'h400 + n);
      #1;
      if (req0_vld && req0_rdy) n++;
      @(posedge clk); #1;
    end
    checks++; if (outstanding !== CW'(MO)) begin failures++; $display("FAIL full_reach got=%0d exp=%0d", outstanding, MO); end
    req0_addr = AW'(32'h400 + n);
    mem_rdata_vld = 1; mem_rdata = rand_data();
    #1;
    checks++; if (mem_vld !== 0 || req0_rdy !== 0) begin failures++; $display("FAIL full_block got mv=%b rdy=%b exp 0 0", mem_vld, req0_rdy); end
    @(posedge clk); #1;
    mem_rdata_vld = 0;
    checks++; if (outstanding !== CW'(MO - 1) || rsp0_vld !== 1) begin failures++; $display("FAIL full_pop got out=%0d rsp0=%b exp out=%0d rsp0=1", outstanding, rsp0_vld, MO - 1); end
    #1;
    checks++; if (mem_vld !== 1 || req0_rdy !== 1 || mem_addr !== AW'(32'h400 + n)) begin failures++; $display("FAIL full_resume got mv=%b rdy=%b addr=%h exp 1 1 %h", mem_vld, req0_rdy, mem_addr, 32'h400 + n); end
    @(posedge clk); #1;
    req0_vld = 0;
    checks++; if (outstanding !== CW'(MO)) begin failures++; $display("FAIL full_refill got=%0d exp=%0d", outstanding, MO); end
  endtask

  task automatic test_empty_beat();
    apply_reset();
    mem_rdata_vld = 1; mem_rdata = rand_data();
    @(posedge clk); #1;
    mem_rdata_vld = 0;
    checks++; if (rsp0_vld !== 0 || rsp1_vld !== 0) begin failures++; $display("FAIL empty_rsp got=%b%b exp=00", rsp0_vld, rsp1_vld); end
    checks++; if (rsp_err !== 1) begin failures++; $display("FAIL empty_err got=%b exp=1", rsp_err); end
    checks++; if (outstanding !== 0) begin failures++; $display("FAIL empty_outstanding got=%0d exp=0", outstanding); end
    @(posedge clk); #1;
    checks++; if (rsp_err !== 1) begin failures++; $display("FAIL empty_err_sticky got=%b exp=1", rsp_err); end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    apply_reset();
    mem_rdy = 1; req0_vld = 1;
    for (int c = 0; c < 20 && outstanding !== CW'(5); c++) begin
      req0_addr = AW'(32'h500 + n);
      #1;
      if (req0_vld && req0_rdy) n++;
      @(posedge clk); #1;
    end
    req0_addr = AW'(32'h500 + n);
    checks++; if (outstanding !== 5) begin failures++; $display("FAIL mid_reach got=%0d exp=5", outstanding); end
    #2 reset_n = 0;
    #1;
    checks++; if (outstanding !== 0 || mem_vld !== 0 || req0_rdy !== 0 || rsp_err !== 0) begin failures++; $display("FAIL mid_async got out=%0d mv=%b rdy=%b err=%b exp 0 0 0 0", outstanding, mem_vld, req0_rdy, rsp_err); end
    req0_vld = 0;
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;
    mem_rdata_vld = 1; mem_rdata = rand_data();
    @(posedge clk); #1;
    mem_rdata_vld = 0;
    checks++; if (rsp_err !== 1 || rsp0_vld !== 0 || rsp1_vld !== 0) begin failures++; $display("FAIL mid_late_beat got err=%b v=%b%b exp err=1 v=00", rsp_err, rsp0_vld, rsp1_vld); end
  endtask

  // Reference model: queue of owners in acceptance order, popped per beat.
  task automatic test_random();
    int            own_q [$];
    bit            exp_vld = 0;
    int            exp_own = 0;
    logic [DW-1:0] exp_dat = '0;
    bit            cur_vld [2] = '{0, 0};
    logic [AW-1:0] cur_addr [2];
    int            run_len = 0, run_own = 0;
    apply_reset();
    for (int c = 0; c < 1000; c++) begin
      bit acc0, acc1, macc, beat;
      checks++; if (outstanding !== CW'(own_q.size())) begin failures++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", c, outstanding, own_q.size()); end
      checks++; if (rsp0_vld !== (exp_vld && exp_own == 0) || rsp1_vld !== (exp_vld && exp_own == 1)) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b%b exp_vld=%b owner=%0d", c, rsp0_vld, rsp1_vld, exp_vld, exp_own); end
      if (exp_vld) begin
        checks++; if ((exp_own == 0 ? rsp0_dat : rsp1_dat) !== exp_dat) begin failures++; $display("FAIL rnd_rsp_data cyc=%0d owner=%0d got=%h exp=%h", c, exp_own, (exp_own == 0 ? rsp0_dat : rsp1_dat), exp_dat); end
      end
      for (int p = 0; p < 2; p++) begin
        if (!cur_vld[p]) begin
          cur_vld[p]  = ($urandom_range(0, 3) != 0);
          cur_addr[p] = AW'($urandom());
        end
      end
      req0_vld = cur_vld[0]; req0_addr = cur_addr[0];
      req1_vld = cur_vld[1]; req1_addr = cur_addr[1];
      mem_rdy  = ($urandom_range(0, 3) != 0);
      beat = (own_q.size() > 0) && ($urandom_range(0, 2) < ((c < 500) ? 1 : 2));
      mem_rdata_vld = beat;
      mem_rdata     = rand_data();
      #1;
      acc0 = req0_vld && req0_rdy;
      acc1 = req1_vld && req1_rdy;
      macc = mem_vld && mem_rdy;
      if (own_q.size() == MO) begin
        checks++; if (mem_vld !== 0 || req0_rdy !== 0 || req1_rdy !== 0) begin failures++; $display("FAIL rnd_full_block cyc=%0d got mv=%b rdy=%b%b exp 0 00", c, mem_vld, req0_rdy, req1_rdy); end
      end
      checks++; if ((acc0 && acc1) || ((acc0 || acc1) != macc)) begin failures++; $display("FAIL rnd_handshake cyc=%0d got acc=%b%b mem=%b", c, acc0, acc1, macc); end
      if (acc0 || acc1) begin
        int own = acc1 ? 1 : 0;
        checks++; if (mem_addr !== cur_addr[own]) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, mem_addr, cur_addr[own]); end
        if (run_len > 0) begin
          checks++; if (own != run_own || run_len >= BL) begin failures++; $display("FAIL rnd_grant cyc=%0d owner=%0d prev=%0d run=%0d max=%0d", c, own, run_own, run_len, BL); end
        end
        run_len = (run_len > 0 && own == run_own) ? run_len + 1 : 1;
        run_own = own;
      end else begin
        run_len = 0;
      end
      exp_vld = beat;
      if (beat) begin
        exp_own = own_q.pop_front();
        exp_dat = mem_rdata;
      end
      if (acc0) begin own_q.push_back(0); cur_vld[0] = 0; end
      if (acc1) begin own_q.push_back(1); cur_vld[1] = 0; end
      @(posedge clk); #1;
    end
    req0_vld = 0; req1_vld = 0; mem_rdata_vld = 0;
    checks++; if (rsp_err !== 0) begin failures++; $display("FAIL rnd_err got=%b exp=0", rsp_err); end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_interleaved_returns();
    test_full();
    test_empty_beat();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
